// File: rtl/loa_acc_32bits.sv
`default_nettype none
// ============================================================================
//  Module   : loa_acc_32bits
//  Brief    : Streaming packet accumulator built on a lower-part-OR adder
//             (LOA). The low APPROX_BITS of each addition are ORed; the upper
//             bits are added exactly, with a carry-in taken from the top
//             approximate bit. One result per packet is returned over a
//             valid/ready handshake.
//  Config   : LOA_ACC_SAT_EN - when defined, an upper-part carry-out
//             saturates the accumulator to all-ones for the rest of the
//             packet. When undefined, the sum wraps and out_ovf flags it.
//  Revision : 1.0 - initial release
// ============================================================================
module loa_acc_32bits #(
    parameter int WIDTH       = 32,
    parameter int APPROX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    // Width of the exactly-added upper part
    localparam int c_HI_W = WIDTH - APPROX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic               r_ovf;

    logic               w_accept;
    logic [APPROX_BITS-1:0] w_lo;
    logic               w_cin;
    logic [c_HI_W:0]    w_hi_sum;
    logic               w_co;
    logic [WIDTH-1:0]   w_loa_sum;
    logic               w_next_ovf;
    logic [WIDTH-1:0]   w_next_acc;

    // Ready depends on state alone so upstream never sees a valid->ready path
    assign in_ready = (r_state != ST_HOLD);
    assign w_accept = in_valid & in_ready;

    // Approximate low part: bitwise OR, no carry chain
    assign w_lo  = r_acc[APPROX_BITS-1:0] | in_data[APPROX_BITS-1:0];

    // The only information the low part passes upward: both top low bits set
    assign w_cin = r_acc[APPROX_BITS-1] & in_data[APPROX_BITS-1];

    // Exact upper part, one extra bit to capture the carry-out
    assign w_hi_sum = {1'b0, r_acc[WIDTH-1:APPROX_BITS]}
                    + {1'b0, in_data[WIDTH-1:APPROX_BITS]}
                    + {{c_HI_W{1'b0}}, w_cin};

    assign w_co      = w_hi_sum[c_HI_W];
    assign w_loa_sum = {w_hi_sum[c_HI_W-1:0], w_lo};

    // Overflow is sticky for the whole packet
    assign w_next_ovf = r_ovf | w_co;

`ifdef LOA_ACC_SAT_EN
    // Once any carry-out has happened in this packet the result pins at all-ones
    assign w_next_acc = w_next_ovf ? {WIDTH{1'b1}} : w_loa_sum;
`else
    // Upper part wraps modulo 2^(WIDTH-APPROX_BITS); out_ovf reports it
    assign w_next_acc = w_loa_sum;
`endif

    // Packet FSM: first beat loads, later beats accumulate, result held until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // First beat is taken verbatim; no add against stale state
                        r_acc <= in_data;
                        r_ovf <= 1'b0;
                        if (in_last) begin
                            out_data  <= in_data;
                            out_ovf   <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end

                ST_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_next_acc;
                        r_ovf <= w_next_ovf;
                        if (in_last) begin
                            out_data  <= w_next_acc;
                            out_ovf   <= w_next_ovf;
                            out_valid <= 1'b1;
                            r_state   <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    // Result stays frozen until downstream takes it
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loa_acc_32bits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loa_acc_32bits
//  Brief    : Self-checking bench for loa_acc_32bits: directed vector table,
//             reset/backpressure/back-to-back sequences and randomized
//             packets compared against an arithmetic LOA reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_loa_acc_32bits;

    localparam int W = 32;
    localparam int L = 8;
`ifdef LOA_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_ovf;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pkt_q[$];

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] d;
        logic [31:0]      exp_wrap;
        logic [31:0]      exp_sat;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    loa_acc_32bits #(.WIDTH(W), .APPROX_BITS(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // LOA reference from the arithmetic definition on 64-bit integers
    function automatic logic [32:0] loa_ref(input logic [31:0] a, input logic [31:0] b);
        longint unsigned av, bv, lo, cin, hi, co, s;
        av  = 64'(a);
        bv  = 64'(b);
        lo  = (av | bv) & ((64'd1 << L) - 1);
        cin = ((av >> (L - 1)) & 1) & ((bv >> (L - 1)) & 1);
        hi  = (av >> L) + (bv >> L) + cin;
        co  = (hi >> (W - L)) & 1;
        s   = ((hi & ((64'd1 << (W - L)) - 1)) << L) | lo;
        return {co[0], s[31:0]};
    endfunction

    // Whole-packet reference: returns {ovf, result}
    function automatic logic [32:0] model_pkt();
        logic [31:0] acc;
        logic        ovf;
        logic [32:0] r;
        acc = pkt_q[0];
        ovf = 1'b0;
        for (int i = 1; i < pkt_q.size(); i++) begin
            r   = loa_ref(acc, pkt_q[i]);
            ovf = ovf | r[32];
            acc = (SAT && ovf) ? 32'hFFFF_FFFF : r[31:0];
        end
        return {ovf, acc};
    endfunction

    function automatic vec_t mk(input int n, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] ew, input logic [31:0] es, input logic eo);
        vec_t v;
        v.n        = 3'(n);
        v.d        = {d3, d2, d1, d0};
        v.exp_wrap = ew;
        v.exp_sat  = es;
        v.exp_ovf  = eo;
        return v;
    endfunction

    // Drive pkt_q as one packet with optional input gaps, then hold the
    // result under backpressure for bp cycles before accepting it
    task automatic send_pkt(input string name, input int gap_max, input int bp,
                            input logic [31:0] exp_d, input logic exp_o);
        int n;
        int t;
        int g;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            in_valid = 1'b0;
            repeat (g) begin
                in_data = $urandom;
                in_last = 1'($urandom_range(0, 1));
                step();
            end
            in_valid = 1'b1;
            in_data  = pkt_q[i];
            in_last  = (i == n - 1);
            t = 0;
            while (!in_ready && t < 20) begin
                step();
                t++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL %s in_ready_timeout actual=0 required=1", name);
            end
            if (i == n - 1) chk({name, "_valid_before_last"}, 32'(out_valid), 32'd0);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, "_latency_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_data"}, out_data, exp_d);
        chk({name, "_ovf"}, 32'(out_ovf), 32'(exp_o));
        repeat (bp) begin
            in_valid  = 1'b1;
            in_data   = $urandom;
            in_last   = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            step();
            chk({name, "_bp_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_bp_data"}, out_data, exp_d);
            chk({name, "_bp_ovf"}, 32'(out_ovf), 32'(exp_o));
            chk({name, "_bp_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk({name, "_release_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [32:0] m;
    logic [31:0] bb_beats[$];
    logic        bb_lasts[$];
    logic [32:0] bb_exp[$];

    initial begin
        int idx;
        int k;
        int bub;
        int cyc;
        logic r;
        int n;
        int mode;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        step();

        // Hand-derived vectors: n, beats, wrap result, saturated result, ovf
        vecs[0] = mk(2, 32'h0000_00F0, 32'h0000_0088, 0, 0, 32'h0000_01F8, 32'h0000_01F8, 1'b0);
        vecs[1] = mk(3, 32'h0000_0110, 32'h0000_0220, 32'h0000_0440, 0, 32'h0000_0770, 32'h0000_0770, 1'b0);
        vecs[2] = mk(2, 32'hFFFF_FF00, 32'h0000_0100, 0, 0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        vecs[3] = mk(1, 32'h1234_5678, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0);
        vecs[4] = mk(2, 32'h0000_0080, 32'h0000_0080, 0, 0, 32'h0000_0180, 32'h0000_0180, 1'b0);
        vecs[5] = mk(3, 32'hFFFF_FF00, 32'h0000_0100, 32'h0000_0005, 0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        vecs[6] = mk(4, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0000_00FF,
                     32'h0600_00FF, 32'h0600_00FF, 1'b0);

        for (int i = 0; i < 7; i++) begin
            pkt_q.delete();
            for (int j = 0; j < int'(vecs[i].n); j++) pkt_q.push_back(vecs[i].d[j]);
            send_pkt($sformatf("vec%0d", i), i % 3, (i == 1) ? 5 : (i % 3),
                     SAT ? vecs[i].exp_sat : vecs[i].exp_wrap, vecs[i].exp_ovf);
        end

        // Reset in the middle of a packet drops the partial sum
        in_valid = 1'b1; in_data = 32'h0000_1111; in_last = 1'b0; step();
        in_data = 32'h0000_2222; step();
        in_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_data", out_data, 32'd0);
        step();
        chk("rst_mid_out_valid2", 32'(out_valid), 32'd0);
        pkt_q.delete(); pkt_q.push_back(32'h1234_5678);
        send_pkt("after_rst", 0, 0, 32'h1234_5678, 1'b0);

        // Reset while a result is pending in HOLD discards it
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back packets with in_valid and out_ready held high
        bb_beats.delete(); bb_lasts.delete(); bb_exp.delete();
        pkt_q = '{32'hFFFF_FF00, 32'h0000_0100};
        m = model_pkt(); bb_exp.push_back(m);
        bb_beats.push_back(pkt_q[0]); bb_lasts.push_back(1'b0);
        bb_beats.push_back(pkt_q[1]); bb_lasts.push_back(1'b1);
        pkt_q = '{32'h0000_00F0, 32'h0000_0088};
        m = model_pkt(); bb_exp.push_back(m);
        bb_beats.push_back(pkt_q[0]); bb_lasts.push_back(1'b0);
        bb_beats.push_back(pkt_q[1]); bb_lasts.push_back(1'b1);
        pkt_q = '{32'h1111_1111};
        m = model_pkt(); bb_exp.push_back(m);
        bb_beats.push_back(pkt_q[0]); bb_lasts.push_back(1'b1);
        pkt_q = '{32'h0000_0080, 32'h0000_0080, 32'h0000_0001};
        m = model_pkt(); bb_exp.push_back(m);
        bb_beats.push_back(pkt_q[0]); bb_lasts.push_back(1'b0);
        bb_beats.push_back(pkt_q[1]); bb_lasts.push_back(1'b0);
        bb_beats.push_back(pkt_q[2]); bb_lasts.push_back(1'b1);

        idx = 0; k = 0; bub = 0; cyc = 0;
        out_ready = 1'b1;
        while (k < bb_exp.size() && cyc < 200) begin
            if (idx < bb_beats.size()) begin
                in_valid = 1'b1;
                in_data  = bb_beats[idx];
                in_last  = bb_lasts[idx];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            r = in_ready;
            step();
            cyc++;
            if (r && idx < bb_beats.size()) idx++;
            else if (!r) bub++;
            if (out_valid) begin
                if (k < bb_exp.size()) begin
                    chk($sformatf("b2b%0d_data", k), out_data, bb_exp[k][31:0]);
                    chk($sformatf("b2b%0d_ovf", k), 32'(out_ovf), 32'(bb_exp[k][32]));
                end
                k++;
            end
        end
        if (k < bb_exp.size()) begin
            checks++;
            failures++;
            $display("FAIL b2b_timeout results=%0d required=%0d", k, bb_exp.size());
        end
        chk("b2b_bubbles", 32'(bub), 32'(bb_exp.size() - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        out_ready = 1'b0;

        // Randomized packets against the reference model
        for (int p = 0; p < 40; p++) begin
            pkt_q.delete();
            n = int'($urandom_range(1, 6));
            mode = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) begin
                case (mode)
                    0:       pkt_q.push_back($urandom);
                    1:       pkt_q.push_back(32'hF000_0000 | $urandom);
                    default: pkt_q.push_back($urandom & 32'h0000_FFFF);
                endcase
            end
            m = model_pkt();
            send_pkt($sformatf("rand%0d", p), 2, int'($urandom_range(0, 3)), m[31:0], m[32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
